operand_input_reg: RTL and testbench

OPERAND_INPUT_REG -- requirements
Module: operand_input_reg

---
 rtl/operand_input_reg.sv | 88 ++++++++
 tb/tb_operand_input_reg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_input_reg.sv
// rtl/operand_input_reg.sv - serial-to-parallel capture of an A/B operand pair, LSB first
module operand_input_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             serial_in,
    input  logic             serial_valid_in,
    input  logic             clr_in,
    input  logic             output_read_in,
    output logic             input_rdy,
    output logic             output_rdy,
    output logic             loading_b,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] FULL   = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
    logic             load_a, load_b;

    always_comb begin
        shifted   = {serial_in, shreg[WIDTH-1:1]};
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        load_a    = 1'b0;
        load_b    = 1'b0;
        if (clr_in) begin
            state_nxt = LOAD_A;
            cnt_nxt   = '0;
            shreg_nxt = '0;
        end else if (state == FULL) begin
            if (output_read_in)
                state_nxt = LOAD_A;
        end else if (serial_valid_in) begin
            shreg_nxt = shifted;
            if (cnt == LAST_BIT) begin
                // Word complete: the operand takes the shifted value, not the stale register
                cnt_nxt = '0;
                if (state == LOAD_A) begin
                    load_a    = 1'b1;
                    state_nxt = LOAD_B;
                end else begin
                    load_b    = 1'b1;
                    state_nxt = FULL;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // Status flags are registered from the next state so outputs never see inputs combinationally
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= LOAD_A;
            cnt        <= '0;
            shreg      <= '0;
            operand_a  <= '0;
            operand_b  <= '0;
            input_rdy  <= 1'b1;
            output_rdy <= 1'b0;
            loading_b  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            input_rdy  <= (state_nxt != FULL);
            output_rdy <= (state_nxt == FULL);
            loading_b  <= (state_nxt == LOAD_B);
            if (load_a)
                operand_a <= shifted;
            if (load_b)
                operand_b <= shifted;
        end
    end

endmodule

// File: tb/tb_operand_input_reg.sv
// tb/tb_operand_input_reg.sv - directed bench with a frame-level reference model
module tb_operand_input_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         serial_in = 1'b0;
    logic         serial_valid = 1'b0;
    logic         clr = 1'b0;
    logic         rd = 1'b0;
    logic         input_rdy, output_rdy, loading_b;
    logic [W-1:0] operand_a, operand_b;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    operand_input_reg #(.WIDTH(W)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid),
        .clr_in          (clr),
        .output_read_in  (rd),
        .input_rdy       (input_rdy),
        .output_rdy      (output_rdy),
        .loading_b       (loading_b),
        .operand_a       (operand_a),
        .operand_b       (operand_b)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a 2W-bit vector indexed by arrival order
    logic [2*W-1:0] m_frame;
    int             m_bits;
    logic           m_full;
    logic [W-1:0]   m_a, m_b;

    function automatic logic [2*W-1:0] put_bit(input logic [2*W-1:0] f, input int idx, input logic b);
        logic [2*W-1:0] r;
        r = f;
        r[idx] = b;
        return r;
    endfunction

    function automatic logic [W-1:0] lo_half(input logic [2*W-1:0] f);
        return f[W-1:0];
    endfunction

    function automatic logic [W-1:0] hi_half(input logic [2*W-1:0] f);
        return f[2*W-1:W];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full  <= 1'b0;
            m_bits  <= 0;
            m_frame <= '0;
            m_a     <= '0;
            m_b     <= '0;
        end else if (clr) begin
            m_full <= 1'b0;
            m_bits <= 0;
        end else if (m_full) begin
            if (rd)
                m_full <= 1'b0;
        end else if (serial_valid) begin
            m_frame <= put_bit(m_frame, m_bits, serial_in);
            if (m_bits == W - 1)
                m_a <= lo_half(put_bit(m_frame, m_bits, serial_in));
            if (m_bits == 2*W - 1) begin
                m_b    <= hi_half(put_bit(m_frame, m_bits, serial_in));
                m_full <= 1'b1;
                m_bits <= 0;
            end else begin
                m_bits <= m_bits + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model input_rdy", 64'(input_rdy), 64'(!m_full));
            chk("model output_rdy", 64'(output_rdy), 64'(m_full));
            chk("model loading_b", 64'(loading_b), 64'(!m_full && m_bits >= W));
            chk("model operand_a", 64'(operand_a), 64'(m_a));
            chk("model operand_b", 64'(operand_b), 64'(m_b));
        end
    end

    task automatic cyc(input logic v, input logic b, input logic c, input logic r);
        @(negedge clk);
        serial_valid = v;
        serial_in    = b;
        clr          = c;
        rd           = r;
    endtask

    task automatic send(input logic [W-1:0] w, input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            cyc(1'b1, w[i], 1'b0, 1'b0);
            if (gaps) begin
                cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
                if ($urandom_range(0, 3) == 0)
                    repeat (3) cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset input_rdy", 64'(input_rdy), 64'd1);
        chk("reset output_rdy", 64'(output_rdy), 64'd0);
        chk("reset loading_b", 64'(loading_b), 64'd0);
        chk("reset operand_a", 64'(operand_a), 64'd0);
        chk("reset operand_b", 64'(operand_b), 64'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Back-to-back frame
        send(32'h3F800000, 0, 31, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("loading_b after bit 32", 64'(loading_b), 64'd1);
        chk("operand_a after A", 64'(operand_a), 64'h3F800000);
        send(32'h40000000, 1, 31, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("output_rdy after frame", 64'(output_rdy), 64'd1);
        chk("input_rdy in full", 64'(input_rdy), 64'd0);
        chk("operand_a frame1", 64'(operand_a), 64'h3F800000);
        chk("operand_b frame1", 64'(operand_b), 64'h40000000);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("output_rdy after read", 64'(output_rdy), 64'd0);

        // Same frame with toggling valid and random gaps
        send(32'h3F800000, 0, 31, 1'b1);
        send(32'h40000000, 0, 31, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gapped output_rdy", 64'(output_rdy), 64'd1);
        chk("gapped operand_a", 64'(operand_a), 64'h3F800000);
        chk("gapped operand_b", 64'(operand_b), 64'h40000000);

        // Valid bits in FULL are ignored
        repeat (10) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("full ignore output_rdy", 64'(output_rdy), 64'd1);
        chk("full ignore operand_a", 64'(operand_a), 64'h3F800000);
        chk("full ignore operand_b", 64'(operand_b), 64'h40000000);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post read output_rdy", 64'(output_rdy), 64'd0);
        chk("post read input_rdy", 64'(input_rdy), 64'd1);
        chk("post read loading_b", 64'(loading_b), 64'd0);

        // Partial frame aborted by clr
        send(32'h12345678, 0, 19, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr holds operand_a", 64'(operand_a), 64'h3F800000);
        chk("clr holds operand_b", 64'(operand_b), 64'h40000000);
        chk("clr loading_b", 64'(loading_b), 64'd0);
        send(32'hC0490FDB, 0, 31, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("new operand_a", 64'(operand_a), 64'hC0490FDB);
        chk("old operand_b held", 64'(operand_b), 64'h40000000);
        send(32'h00000001, 1, 31, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("final operand_a", 64'(operand_a), 64'hC0490FDB);
        chk("final operand_b", 64'(operand_b), 64'h00000001);

        // clr and read together in FULL
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr+read output_rdy", 64'(output_rdy), 64'd0);
        chk("clr+read input_rdy", 64'(input_rdy), 64'd1);
        chk("clr+read operand_a", 64'(operand_a), 64'hC0490FDB);
        chk("clr+read operand_b", 64'(operand_b), 64'h00000001);

        // Asynchronous reset after 40 bits
        send(32'hA5A5A5A5, 0, 31, 1'b0);
        send(32'h0000005A, 0, 7, 1'b0);
        @(posedge clk);
        #2;
        serial_valid = 1'b0;
        rst          = 1'b1;
        #1;
        chk("async rst input_rdy", 64'(input_rdy), 64'd1);
        chk("async rst output_rdy", 64'(output_rdy), 64'd0);
        chk("async rst loading_b", 64'(loading_b), 64'd0);
        chk("async rst operand_a", 64'(operand_a), 64'd0);
        chk("async rst operand_b", 64'(operand_b), 64'd0);
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        serial_valid = 1'b1;
        serial_in    = 1'b1;
        send(32'hFFFFFFFF, 1, 31, 1'b0);
        send(32'h80000000, 0, 31, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post rst output_rdy", 64'(output_rdy), 64'd1);
        chk("post rst operand_a", 64'(operand_a), 64'hFFFFFFFF);
        chk("post rst operand_b", 64'(operand_b), 64'h80000000);

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
